// File: rtl/hires_fill_ctrl.sv
// Rectangle fill engine and port-A arbiter for the 20K hires RAM ({x, y} addressing).
// Define HIRES_FILL_XOR_EN to build the read-modify-write XOR fill mode.
module hires_fill_ctrl #(
  parameter int ADDR_X_W = 7,
  parameter int ADDR_Y_W = 8
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         cfg_we,
  input  logic [2:0]                   cfg_addr,
  input  logic [7:0]                   cfg_din,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_X_W+ADDR_Y_W-1:0] cpu_addr,
  input  logic [7:0]                   cpu_wdata,
  output logic                         cpu_ack,
  output logic                         mem_ce,
  output logic                         mem_we,
  output logic [ADDR_X_W+ADDR_Y_W-1:0] mem_addr,
  output logic [7:0]                   mem_din,
  output logic                         mem_oce,
  input  logic [7:0]                   mem_dout,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   status
);
  localparam int CW = ADDR_X_W + ADDR_Y_W + 1;

`ifdef HIRES_FILL_XOR_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FILL = 3'd1, S_FINISH = 3'd2,
    S_RD = 3'd3, S_WAIT1 = 3'd4, S_WAIT2 = 3'd5, S_WR = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FILL = 3'd1, S_FINISH = 3'd2
  } state_t;
`endif

  state_t state;

  logic [ADDR_X_W-1:0] x0_r, w_r, xc, nxt_xc;
  logic [ADDR_Y_W-1:0] y0_r, h_r, yc, ycnt, nxt_yc, nxt_ycnt, h_last;
  logic [7:0]          pat_r;
  logic [CW-1:0]       rem, w_eff, h_eff, total;
  logic                cmd_wr, abort, start, last, col_end;
  logic                cpu_grant, rmw_lock, cpu_rd_q, xor_bit;

  assign cmd_wr = cfg_we && (cfg_addr == 3'd5);
  assign abort  = cmd_wr && cfg_din[7];
  assign start  = cmd_wr && cfg_din[0] && !cfg_din[7] && !busy;

  assign busy = (state != S_IDLE) && (state != S_FINISH);
  assign done = (state == S_FINISH);

  // Zero in W/H selects the full 128 columns / 256 lines.
  assign w_eff = (w_r == '0) ? (CW'(1) << ADDR_X_W) : CW'(w_r);
  assign h_eff = (h_r == '0) ? (CW'(1) << ADDR_Y_W) : CW'(h_r);
  assign total = w_eff * h_eff;

  assign h_last  = h_r - ADDR_Y_W'(1);
  assign col_end = (ycnt == h_last);
  assign last    = (rem == CW'(1));

  // y is the inner loop; wraps on its own and reloads Y0 at column end.
  always_comb begin
    nxt_xc   = xc;
    nxt_yc   = yc + ADDR_Y_W'(1);
    nxt_ycnt = ycnt + ADDR_Y_W'(1);
    if (col_end) begin
      nxt_xc   = xc + ADDR_X_W'(1);
      nxt_yc   = y0_r;
      nxt_ycnt = '0;
    end
  end

`ifdef HIRES_FILL_XOR_EN
  logic       xor_q, abort_pend;
  logic [7:0] rd_q;
  assign rmw_lock = (state == S_WAIT1) || (state == S_WAIT2) || (state == S_WR);
  assign xor_bit  = xor_q;
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
  assign rmw_lock    = 1'b0;
  assign xor_bit     = 1'b0;
`endif

  assign cpu_grant = cpu_req && !rmw_lock && !srst;
  assign status    = {busy, xor_bit, 6'b0};

  always_comb begin
    cpu_ack  = 1'b0;
    mem_ce   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (cpu_grant) begin
      cpu_ack  = 1'b1;
      mem_ce   = 1'b1;
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_we ? cpu_wdata : 8'h00;
    end else begin
      case (state)
        S_FILL: begin
          mem_ce   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {xc, yc};
          mem_din  = pat_r;
        end
`ifdef HIRES_FILL_XOR_EN
        S_RD: begin
          mem_ce   = 1'b1;
          mem_addr = {xc, yc};
        end
        S_WR: begin
          mem_ce   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {xc, yc};
          mem_din  = rd_q ^ pat_r;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef HIRES_FILL_XOR_EN
  assign mem_oce = cpu_rd_q || (state == S_WAIT1);
`else
  assign mem_oce = cpu_rd_q;
`endif

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state    <= S_IDLE;
      x0_r     <= '0;
      y0_r     <= '0;
      w_r      <= '0;
      h_r      <= '0;
      pat_r    <= '0;
      xc       <= '0;
      yc       <= '0;
      ycnt     <= '0;
      rem      <= '0;
      cpu_rd_q <= 1'b0;
`ifdef HIRES_FILL_XOR_EN
      xor_q      <= 1'b0;
      abort_pend <= 1'b0;
      rd_q       <= '0;
`endif
    end else begin
      cpu_rd_q <= cpu_grant && !cpu_we;
      if (cfg_we && !busy) begin
        case (cfg_addr)
          3'd0: x0_r  <= cfg_din[ADDR_X_W-1:0];
          3'd1: y0_r  <= cfg_din[ADDR_Y_W-1:0];
          3'd2: w_r   <= cfg_din[ADDR_X_W-1:0];
          3'd3: h_r   <= cfg_din[ADDR_Y_W-1:0];
          3'd4: pat_r <= cfg_din;
          default: ;
        endcase
      end
      case (state)
        S_IDLE, S_FINISH: begin
          state <= S_IDLE;
          if (start) begin
            xc   <= x0_r;
            yc   <= y0_r;
            ycnt <= '0;
            rem  <= total;
`ifdef HIRES_FILL_XOR_EN
            xor_q      <= cfg_din[1];
            abort_pend <= 1'b0;
            state      <= cfg_din[1] ? S_RD : S_FILL;
`else
            state <= S_FILL;
`endif
          end
        end
        S_FILL: begin
          if (abort) state <= S_FINISH;
          else if (!cpu_grant) begin
            xc   <= nxt_xc;
            yc   <= nxt_yc;
            ycnt <= nxt_ycnt;
            rem  <= rem - CW'(1);
            if (last) state <= S_FINISH;
          end
        end
`ifdef HIRES_FILL_XOR_EN
        // Once the read issues, the byte completes before an abort takes effect.
        S_RD: begin
          if (!cpu_grant) begin
            state      <= S_WAIT1;
            abort_pend <= abort;
          end else if (abort) state <= S_FINISH;
        end
        S_WAIT1: begin
          abort_pend <= abort_pend || abort;
          state      <= S_WAIT2;
        end
        S_WAIT2: begin
          abort_pend <= abort_pend || abort;
          rd_q       <= mem_dout;
          state      <= S_WR;
        end
        S_WR: begin
          xc    <= nxt_xc;
          yc    <= nxt_yc;
          ycnt  <= nxt_ycnt;
          rem   <= rem - CW'(1);
          state <= (last || abort_pend || abort) ? S_FINISH : S_RD;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hires_fill_ctrl.sv
// Randomized self-checking bench for hires_fill_ctrl with a queue-based expected-write model.
module tb_hires_fill_ctrl;
  logic        clk = 1'b0, srst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_din = '0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack, mem_ce, mem_we, mem_oce, busy, done;
  logic [14:0] mem_addr;
  logic [7:0]  mem_din, mem_dout, status;

  hires_fill_ctrl dut (
    .clk(clk), .srst(srst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_din(cfg_din),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_oce(mem_oce), .mem_dout(mem_dout),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

`ifdef HIRES_FILL_XOR_EN
  localparam bit XB = 1'b1;
`else
  localparam bit XB = 1'b0;
`endif

  int errs = 0, checks = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // RAM model: 2-cycle read (ce, then oce), plus a backdoor preload port.
  logic [7:0]  ram [0:32767];
  logic [7:0]  rd1;
  logic        pl_en = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [7:0]  pl_val = '0;
  always @(posedge clk) begin
    if (mem_ce && !mem_we) rd1 <= ram[mem_addr];
    if (mem_ce && mem_we) ram[mem_addr] <= mem_din;
    if (pl_en) ram[pl_addr] <= pl_val;
    if (mem_oce) mem_dout <= rd1;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: collects engine writes, counts done pulses, checks CPU arbitration.
  int   wq_addr[$], wq_data[$], wq_cyc[$];
  int   done_cnt = 0;
  bit   xor_quiet = 1'b0, prev_rd = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!srst) begin
      if (mem_ce && mem_we && !cpu_ack) begin
        wq_addr.push_back(int'(mem_addr));
        wq_data.push_back(int'(mem_din));
        wq_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (prev_rd) chk("cpu_rd_oce", mem_oce, 1);
      if (cpu_req && !xor_quiet) begin
        chk("cpu_ack", cpu_ack, 1);
        chk("cpu_mem_addr", mem_addr, cpu_addr);
        chk("cpu_mem_we", mem_we, cpu_we);
        if (cpu_we) chk("cpu_mem_din", mem_din, cpu_wdata);
      end
      prev_rd = cpu_req && cpu_ack && !cpu_we;
    end else prev_rd = 1'b0;
  end

  int m_x0 = 0, m_y0 = 0, m_w = 0, m_h = 0, m_pat = 0;
  int ex_a[$], ex_d[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = a[2:0]; cfg_din = d[7:0];
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_regs(input int x0, input int y0, input int w, input int h, input int pat);
    cfg_wr(0, x0); cfg_wr(1, y0); cfg_wr(2, w); cfg_wr(3, h); cfg_wr(4, pat);
    m_x0 = x0; m_y0 = y0; m_w = w; m_h = h; m_pat = pat;
  endtask

  // Expected write list straight from the rectangle definition.
  task automatic build_exp(input bit xm);
    int we_, he_, a;
    we_ = (m_w == 0) ? 128 : m_w;
    he_ = (m_h == 0) ? 256 : m_h;
    ex_a.delete(); ex_d.delete();
    for (int i = 0; i < we_; i++)
      for (int j = 0; j < he_; j++) begin
        a = (((m_x0 + i) % 128) << 8) | ((m_y0 + j) % 256);
        ex_a.push_back(a);
        ex_d.push_back(xm ? (m_pat ^ int'(ram[a])) : m_pat);
      end
  endtask

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic check_seq(input string tag);
    int mism;
    mism = 0;
    chk({tag, "_count"}, wq_addr.size(), ex_a.size());
    for (int k = 0; k < wq_addr.size() && k < ex_a.size(); k++)
      if (wq_addr[k] != ex_a[k] || wq_data[k] != ex_d[k]) mism++;
    chk({tag, "_seq_mism"}, mism, 0);
  endtask

  task automatic wait_done(input int bound, input bit cpu_mode, input logic [7:0] st, output int dc);
    dc = -1;
    for (int k = 0; k < bound; k++) begin
      if (cpu_mode) begin
        cpu_req   = ($urandom_range(0, 2) == 0);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = 15'($urandom);
        cpu_wdata = 8'($urandom);
      end
      @(negedge clk);
      if (k == 0) chk("status_busy", status, st);
      if (done) begin
        dc = cyc;
        chk("busy_at_done", busy, 0);
        break;
      end
      @(posedge clk); #1;
    end
    if (dc >= 0) tick();
    cpu_req = 1'b0;
    if (dc < 0) chk("done_timeout", 0, 1);
    else begin
      chk("done_one_cycle", done, 0);
      chk("idle_after", busy, 0);
    end
  endtask

  task automatic run_fill(input string tag, input int x0, input int y0, input int w, input int h,
                          input int pat, input bit xr, input bit cpu_mode);
    int t, dc, n, per;
    bit xm;
    xm = xr && XB;
    set_regs(x0, y0, w, h, pat);
    build_exp(xm);
    n = ex_a.size();
    per = xm ? 4 : 1;
    clear_mon();
    xor_quiet = xm;
    t = cyc;
    cfg_wr(5, xr ? 8'h03 : 8'h01);
    wait_done(n * per * 3 + 50, cpu_mode && !xm, {1'b1, xm, 6'b0}, dc);
    check_seq(tag);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    if (!(cpu_mode && !xm)) begin
      chk({tag, "_done_t"}, dc, t + n * per + 1);
      if (wq_cyc.size() > 0) begin
        chk({tag, "_first_t"}, wq_cyc[0], t + per);
        chk({tag, "_last_t"}, wq_cyc[wq_cyc.size() - 1], t + n * per);
      end
    end
    xor_quiet = 1'b0;
  endtask

  initial begin
    int t, dc, ack_c;
    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_cpu_ack", cpu_ack, 0); chk("rst_mem_ce", mem_ce, 0);
    chk("rst_mem_we", mem_we, 0);  chk("rst_mem_oce", mem_oce, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_din", mem_din, 0);
    chk("rst_status", status, 0);
    srst = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    // Basic rectangle
    run_fill("basic", 5, 10, 2, 3, 8'hAA, 1'b0, 1'b0);
    if (wq_addr.size() > 0) chk("basic_first_addr", wq_addr[0], 15'h050A);
    if (wq_addr.size() > 5) chk("basic_last_addr", wq_addr[5], 15'h060C);

    // y wraps without carry into x
    run_fill("ywrap", 40, 8'hFE, 1, 4, 8'h3C, 1'b0, 1'b0);
    // XOR request bit: ignored unless the feature is built
    run_fill("cmd_xor", 127, 8'hFF, 2, 2, 8'h96, 1'b1, 1'b0);

    // Randomized fills, alternating CPU traffic
    for (int r = 0; r < 8; r++)
      run_fill("rand", $urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(1, 6),
               $urandom_range(1, 8), $urandom_range(0, 255), (r % 3) == 0, (r % 2) == 1);

    // Writes and starts while busy are ignored
    set_regs(20, 30, 2, 2, 8'h5A);
    build_exp(1'b0);
    clear_mon();
    t = cyc;
    cfg_wr(5, 8'h01);
    cfg_wr(0, 8'h33);
    cfg_wr(5, 8'h01);
    wait_done(40, 1'b0, 8'h80, dc);
    chk("busy_ign_done_t", dc, t + 5);
    check_seq("busy_ign");

    // Abort after 3 of 6 bytes
    set_regs(5, 10, 2, 3, 8'h11);
    clear_mon();
    t = cyc;
    cfg_wr(5, 8'h01);
    tick(); tick();
    cfg_wr(5, 8'h80);
    @(negedge clk);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    tick(); tick();
    chk("abort_writes", wq_addr.size(), 3);
    chk("abort_done_cnt", done_cnt, 1);
    run_fill("after_abort", 9, 200, 1, 2, 8'h42, 1'b0, 1'b0);

    // Start and abort together: nothing starts
    clear_mon();
    cfg_wr(5, 8'h81);
    tick(); tick();
    chk("start_abort_busy", busy, 0);
    chk("start_abort_writes", wq_addr.size(), 0);
    chk("start_abort_done", done_cnt, 0);

    // Full-RAM fill: W=0, H=0
    run_fill("full", 0, 0, 0, 0, 8'hC3, 1'b0, 1'b0);

    // Asynchronous reset mid-fill
    set_regs(1, 2, 0, 0, 8'h77);
    clear_mon();
    cfg_wr(5, 8'h01);
    tick(); tick(); tick();
    #2 srst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mem_ce", mem_ce, 0);
    chk("arst_done", done, 0);
    tick(); tick();
    srst = 1'b0;
    m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0; m_pat = 0;
    done_cnt = 0;
    tick(); tick();
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle", busy, 0);
    run_fill("post_arst", 3, 4, 2, 2, 8'h3C, 1'b0, 1'b1);

`ifdef HIRES_FILL_XOR_EN
    // Directed XOR byte: CPU held off through the RMW
    pl_en = 1'b1; pl_addr = 15'h0307; pl_val = 8'h0F;
    tick();
    pl_en = 1'b0;
    set_regs(3, 7, 1, 1, 8'hFF);
    clear_mon();
    xor_quiet = 1'b1;
    t = cyc;
    cfg_wr(5, 8'h03);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
    ack_c = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) chk("xor_status", status, 8'hC0);
      if (cpu_ack && ack_c < 0) ack_c = cyc;
      @(posedge clk); #1;
      if (ack_c >= 0) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    xor_quiet = 1'b0;
    chk("xor_ack_t", ack_c, t + 5);
    chk("xor_writes", wq_addr.size(), 1);
    if (wq_addr.size() > 0) begin
      chk("xor_wr_t", wq_cyc[0], t + 4);
      chk("xor_wr_data", wq_data[0], 8'hF0);
    end
    chk("xor_done_cnt", done_cnt, 1);
    run_fill("xor_rand", 60, 250, 2, 3, 8'h5C, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hires_fill_ctrl.md
Name: hires_fill_ctrl

Overview:
- Blitter-style fill engine and port-A arbiter for the 20K hires graphics RAM (address {x[6:0], y[7:0]}).
- Fills a rectangle with a pattern byte on command from Z80 config writes.
- Shares RAM port A with the existing Z80 data-port path; CPU always wins a free cycle.
- Sits between the Z80 I/O decode and the hires RAM port A; the video port B is untouched.

Parameters:
- ADDR_X_W, 7, x (column-byte) field width
- ADDR_Y_W, 8, y (line) field width

Ports:
- clk  in  1  system clock
- srst  in  1  reset; asynchronous, active-high
- cfg_we  in  1  one-cycle config register write strobe
- cfg_addr  in  3  register select: 0=X0, 1=Y0, 2=W, 3=H, 4=PAT, 5=CMD
- cfg_din  in  8  config write data
- cpu_req  in  1  CPU RAM access request; held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  15  CPU address {x, y}
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  CPU access issued to RAM this cycle
- mem_ce  out  1  RAM port A clock enable
- mem_we  out  1  RAM port A write enable
- mem_addr  out  15  RAM port A address
- mem_din  out  8  RAM port A write data
- mem_oce  out  1  RAM port A output-register enable
- mem_dout  in  8  RAM port A read data (valid 2 cycles after ce)
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse when a fill completes or is aborted
- status  out  8  {busy, xor_active, 6'b0}

Behaviour:
- Reset: busy=0, done=0, cpu_ack=0, mem_ce=0, mem_we=0, mem_oce=0, mem_addr=0, mem_din=0. Registers reset to X0=0, Y0=0, W=0, H=0, PAT=0.
- Reset mid-fill: the fill is dropped immediately. No done pulse.
- Config registers:
  - Regs 0–4 accept writes only when busy=0; writes while busy are ignored.
  - CMD bits: bit0=start, bit1=xor mode, bit7=abort.
  - W=0 means 128 columns; H=0 means 256 lines.
- Start:
  - A CMD write with bit0=1 and busy=0 at cycle t gives busy=1 at t+1.
  - The engine latches the cursor xc=X0, yc=Y0 and the counters.
  - Start while busy is ignored. Start and abort in the same write: abort wins, nothing starts.
- States:
  - IDLE: busy=0.
  - FILL: one write per granted cycle.
  - RD, WAIT1, WAIT2, WR: XOR mode only (see Optional Feature).
  - FINISH: done=1, busy falls in the same cycle, then IDLE.
- Scan order:
  - y is the inner loop: yc increments modulo 256 and wraps without carry into x.
  - After H lines, yc reloads Y0 and xc increments modulo 128.
  - The fill ends after W×H bytes.
- Arbitration (combinational mux, registered state):
  - cpu_req=1 and engine not in WAIT1/WAIT2/WR: CPU drives mem_* and cpu_ack=1 that cycle; the engine stalls with cursor unchanged.
  - CPU reads also assert mem_oce in the cycle after ack.
  - Otherwise the engine drives mem_*; cpu_ack=0.
- Abort: a CMD write with bit7=1 while busy.
  - Any in-flight RMW finishes its write first.
  - Then FINISH.
- Throughput: write mode with no CPU traffic = 1 byte/clk; the last write at cycle t+W×H gives done at t+W×H+1.

Optional Feature:
- Macro: HIRES_FILL_XOR_EN.
- Defined:
  - CMD bit1 selects XOR fill. Each byte runs RD (ce, we=0) → WAIT1 (oce=1) → WAIT2 (sample mem_dout) → WR (write mem_dout^PAT), 4 clk/byte.
  - Once RD issues, WAIT1/WAIT2/WR are atomic and the CPU is held off (cpu_ack=0).
  - status[6] reflects the latched XOR mode.
- Undefined:
  - CMD bit1 is ignored, status[6]=0, and the RMW states do not exist.
  - mem_dout is unused.

Test Plan:
- X0=5, Y0=10, W=2, H=3, PAT=0xAA, start with no CPU traffic → writes at 0x050A, 0x050B, 0x050C, 0x060A, 0x060B, 0x060C on 6 consecutive cycles; done one cycle after the last write; busy low.
- Y0=0xFE, H=4, W=1 → addresses y=FE, FF, 00, 01 with x unchanged; W=0, H=0 → exactly 32768 writes, then done.
- cpu_req held during a fill → cpu_ack the same cycle, mem_addr=cpu_addr; the engine repeats its stalled address next cycle; total bytes unchanged.
- Abort after 3 of 6 bytes → exactly 3 writes; done pulse; a subsequent X0 write is accepted.
- srst asserted mid-fill → busy=0 and mem_ce=0 asynchronously; no done pulse; a new start works.
- (XOR_EN) RAM preloaded with 0x0F, PAT=0xFF, W=1, H=1 → writes 0xF0 at cycle 4; cpu_req raised at cycle 2 is acked only at cycle 5.
